// File: rtl/axis_stream_buffer.sv
// Circular FIFO that turns a handshake-less (valid-only) stream into an AXI-Stream
// master with tready backpressure; words arriving while full are dropped and counted.
module axis_stream_buffer #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_WIDTH       = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    input  logic                        clear,
    output logic [ADDR_WIDTH:0]         fifo_count,
    output logic                        overflow,
    output logic [31:0]                 drop_count
);

    localparam int                DEPTH      = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [AXIS_TDATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0]       r_wr_ptr;
    logic [ADDR_WIDTH-1:0]       r_rd_ptr;
    logic [ADDR_WIDTH:0]         r_count;
    logic                        r_overflow;
    logic [31:0]                 r_drop_count;

    logic w_full;
    logic w_empty;
    logic w_wr_en;
    logic w_rd_en;
    logic w_drop;

    // Full/empty come from registered count only: a drop is decided without
    // looking ahead to a read happening in the same cycle.
    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_wr_en = s_axis_tvalid & ~w_full;
    assign w_drop  = s_axis_tvalid &  w_full;
    assign w_rd_en = m_axis_tready & ~w_empty;

    // NOTE: storage has no reset so it maps onto RAM; validity is tracked by the
    // pointers and count, which are reset.
    always_ff @(posedge aclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop takes priority over clear, so a coincident clear restarts the count at 1.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clear) begin
                r_drop_count <= 32'd1;
            end else if (r_drop_count != 32'hFFFF_FFFF) begin
                r_drop_count <= r_drop_count + 32'd1;
            end
        end else if (clear) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end
    end

    assign m_axis_tdata  = r_mem[r_rd_ptr];
    assign m_axis_tvalid = ~w_empty;
    assign fifo_count    = r_count;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_count;

endmodule

// File: tb/tb_axis_stream_buffer.sv
// Self-checking bench for axis_stream_buffer: queue-based reference model compared
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_axis_stream_buffer;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          clear = 1'b0;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic [31:0]   drop_count;

    int checks   = 0;
    int failures = 0;

    axis_stream_buffer #(.AXIS_TDATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .clear         (clear),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of stored words plus status counters.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] rx[$];
    bit            m_ovf = 0;
    int unsigned   m_drops = 0;
    bit            m_init = 0;

    always @(posedge aclk) begin
        bit was_full;
        bit do_read;
        if (!aresetn) begin
            mq.delete();
            m_ovf   = 0;
            m_drops = 0;
            m_init  = 1;
        end else if (m_init) begin
            was_full = (mq.size() == DEPTH);
            do_read  = (mq.size() != 0) && m_axis_tready;
            if (do_read) rx.push_back(mq.pop_front());
            if (s_axis_tvalid && !was_full) begin
                mq.push_back(s_axis_tdata);
            end
            if (s_axis_tvalid && was_full) begin
                m_ovf   = 1;
                m_drops = clear ? 1 : ((m_drops == 32'hFFFF_FFFF) ? m_drops : m_drops + 1);
            end else if (clear) begin
                m_ovf   = 0;
                m_drops = 0;
            end
        end
    end

    // Per-cycle compare against the model, plus AXI-Stream stability of stalled beats.
    logic          p_hold = 1'b0;
    logic [DW-1:0] p_data = '0;

    always @(negedge aclk) begin
        if (m_init) begin
            check("cyc_tvalid", m_axis_tvalid, (mq.size() != 0));
            check("cyc_count", fifo_count, mq.size());
            check("cyc_overflow", overflow, m_ovf);
            check("cyc_drops", drop_count, m_drops);
            if (mq.size() != 0) check("cyc_tdata", m_axis_tdata, mq[0]);
            if (p_hold) begin
                check("stall_tvalid", m_axis_tvalid, 1'b1);
                check("stall_tdata", m_axis_tdata, p_data);
            end
            p_hold = m_axis_tvalid && !m_axis_tready && aresetn;
            p_data = m_axis_tdata;
        end
    end

    task automatic cyc(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = rdy;
        clear         = clr;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int errs;

        // Reset state
        aresetn = 1'b0;
        cyc(0, '0, 0, 0);
        cyc(0, '0, 0, 0);
        aresetn = 1'b1;
        check("rst_tvalid", m_axis_tvalid, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_drops", drop_count, 0);

        // Single word with ready high: one cycle of valid then empty again
        cyc(1, 32'hDEAD_BEEF, 1, 0);
        check("single_tvalid", m_axis_tvalid, 1'b1);
        check("single_tdata", m_axis_tdata, 32'hDEAD_BEEF);
        check("single_count", fifo_count, 1);
        cyc(0, '0, 1, 0);
        check("single_empty_tvalid", m_axis_tvalid, 1'b0);
        check("single_empty_count", fifo_count, 0);

        // Fill and overflow with ready low: 18 writes, 2 dropped
        for (int i = 0; i < 18; i++) cyc(1, i, 0, 0);
        check("fill_count", fifo_count, 16);
        check("fill_overflow", overflow, 1'b1);
        check("fill_drops", drop_count, 2);
        for (int k = 0; k < 16; k++) begin
            check("drain_tvalid", m_axis_tvalid, 1'b1);
            check("drain_tdata", m_axis_tdata, k);
            cyc(0, '0, 1, 0);
        end
        check("drain_done_tvalid", m_axis_tvalid, 1'b0);
        cyc(0, '0, 0, 1);
        check("clr_overflow", overflow, 1'b0);
        check("clr_drops", drop_count, 0);

        // Concurrent read/write at count 5
        for (int i = 0; i < 5; i++) cyc(1, 200 + i, 0, 0);
        check("conc_pre_count", fifo_count, 5);
        for (int k = 0; k < 10; k++) begin
            check("conc_tdata", m_axis_tdata, (k < 5) ? 200 + k : 300 + k - 5);
            cyc(1, 300 + k, 1, 0);
            check("conc_count", fifo_count, 5);
        end
        for (int k = 0; k < 5; k++) cyc(0, '0, 1, 0);
        check("conc_drained", fifo_count, 0);

        // Wrap-around with random backpressure, occupancy held below depth
        rx.delete();
        for (int i = 0; i < 100; i++) begin
            cyc(1, 1000 + i, (mq.size() >= 12) ? 1'b1 : 1'($urandom_range(0, 1)), 0);
        end
        for (int k = 0; k < 40 && mq.size() != 0; k++) cyc(0, '0, 1'($urandom_range(0, 1)), 0);
        for (int k = 0; k < 20 && mq.size() != 0; k++) cyc(0, '0, 1, 0);
        check("wrap_rx_len", rx.size(), 100);
        errs = 0;
        for (int i = 0; i < rx.size() && i < 100; i++) if (rx[i] !== DW'(1000 + i)) errs++;
        check("wrap_order_errs", errs, 0);
        check("wrap_overflow", overflow, 1'b0);
        check("wrap_empty", m_axis_tvalid, 1'b0);

        // Clear after 3 drops, then clear coincident with a drop
        for (int i = 0; i < 19; i++) cyc(1, 500 + i, 0, 0);
        check("clr3_drops", drop_count, 3);
        check("clr3_overflow", overflow, 1'b1);
        cyc(0, '0, 0, 1);
        check("clr3_drops_after", drop_count, 0);
        check("clr3_overflow_after", overflow, 1'b0);
        check("clr3_count_kept", fifo_count, 16);
        check("clr3_head_kept", m_axis_tdata, 500);
        cyc(1, 32'h1234, 0, 1);
        check("clrdrop_drops", drop_count, 1);
        check("clrdrop_overflow", overflow, 1'b1);
        for (int k = 0; k < 16; k++) cyc(0, '0, 1, 0);
        check("clrdrop_drained", fifo_count, 0);

        // Reset mid-stream with 7 words stored and overflow still set
        for (int i = 0; i < 7; i++) cyc(1, 700 + i, 0, 0);
        check("mrst_pre_count", fifo_count, 7);
        aresetn = 1'b0;
        cyc(0, '0, 0, 0);
        aresetn = 1'b1;
        check("mrst_count", fifo_count, 0);
        check("mrst_tvalid", m_axis_tvalid, 1'b0);
        check("mrst_overflow", overflow, 1'b0);
        check("mrst_drops", drop_count, 0);
        cyc(1, 32'h55, 1, 0);
        check("mrst_first_tvalid", m_axis_tvalid, 1'b1);
        check("mrst_first_tdata", m_axis_tdata, 32'h55);
        cyc(0, '0, 1, 0);
        check("mrst_after_tvalid", m_axis_tvalid, 1'b0);

        cyc(0, '0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_stream_buffer.md
# axis_stream_buffer

Buffers the handshake-less AXI-Stream produced by the AXI4-Lite-to-stream writer. The writer has no `tready`, so each accepted AXI write becomes a one-cycle `tvalid` pulse. This block stores those words in a circular FIFO and presents them on a full AXI-Stream master with `tready` backpressure. Overflow is detected, counted and reported so that software can tell when a consumer fell behind.

## Interface
- `AXIS_TDATA_WIDTH`, default 32: data word width.
- `ADDR_WIDTH`, default 4: FIFO depth is 2^ADDR_WIDTH words (default 16).
- `aclk`, input, 1: clock; all logic on the rising edge.
- `aresetn`, input, 1: reset, synchronous, active-low; clock `aclk`.
- `s_axis_tdata`, input, AXIS_TDATA_WIDTH: incoming word.
- `s_axis_tvalid`, input, 1: word valid. There is no `s_axis_tready`; every asserted cycle is one word.
- `m_axis_tdata`, output, AXIS_TDATA_WIDTH: head-of-FIFO word.
- `m_axis_tvalid`, output, 1: FIFO not empty.
- `m_axis_tready`, input, 1: consumer accepts the head word.
- `clear`, input, 1: single-cycle pulse that clears the overflow flag and the drop counter.
- `fifo_count`, output, ADDR_WIDTH+1: number of stored words, 0 to 2^ADDR_WIDTH.
- `overflow`, output, 1: sticky; set when any word has been dropped.
- `drop_count`, output, 32: dropped-word count; saturates at 0xFFFFFFFF.

## Operation
- State: storage array `mem[2^ADDR_WIDTH]` (not reset), `wr_ptr` and `rd_ptr` (ADDR_WIDTH bits each, wrapping modulo depth), `count` (ADDR_WIDTH+1 bits), `overflow`, and `drop_count`.
- full = (count == 2^ADDR_WIDTH). empty = (count == 0). Both are evaluated from registered state at the start of the cycle.
- Write: when `s_axis_tvalid` is high and the FIFO is not full, store `mem[wr_ptr]` <= `s_axis_tdata` and increment `wr_ptr`.
- Drop: when `s_axis_tvalid` is high and the FIFO is full, discard the word.
  - Set `overflow` to 1.
  - Increment `drop_count`, unless it is already 0xFFFFFFFF.
  - A drop happens even if a read occurs in the same cycle. The full test does not look ahead to the read.
- Read: when `m_axis_tvalid` and `m_axis_tready` are both high, increment `rd_ptr`.
- Output data: `m_axis_tdata` = `mem[rd_ptr]`, asynchronous read (first-word fall-through).
- Output valid: `m_axis_tvalid` = ~empty, taken from registered `count`.
- Count update:
  - Write only: count + 1.
  - Read only: count − 1.
  - Write and read in the same cycle: unchanged. This is legal whenever the FIFO is neither empty nor full.
- Empty with a write and `m_axis_tready` high: no read that cycle. The word appears on the output the next cycle.
- `clear` behaviour:
  - `clear` alone: `overflow` <= 0 and `drop_count` <= 0 on the next edge.
  - `clear` in the same cycle as a drop: the drop wins, giving `overflow` = 1 and `drop_count` = 1.
  - `clear` never touches FIFO contents or pointers.
- `fifo_count` = `count` and `overflow` = the `overflow` register, both direct.
- AXI-Stream rules on the master side:
  - Once `m_axis_tvalid` is high, it stays high until the word is accepted.
  - `m_axis_tdata` is stable while `m_axis_tvalid` is high and `m_axis_tready` is low. Writes never alter `mem[rd_ptr]` when the FIFO is not full.

## Timing
- Reset (`aresetn` low at an edge):
  - `wr_ptr`, `rd_ptr` and `count` = 0.
  - `overflow` = 0 and `drop_count` = 0.
  - `m_axis_tvalid` = 0 and `fifo_count` = 0.
  - `m_axis_tdata` is don't-care while `m_axis_tvalid` is 0.
- Reset mid-operation: all stored words are discarded; the first word after reset is released and is the first read out.
- Write-to-valid latency: a word written at edge N is visible at edge N+1. `m_axis_tvalid` and `m_axis_tdata` are valid in the cycle after `s_axis_tvalid`.
- Throughput: one write and one read per cycle, sustained indefinitely.
- Status latency: `fifo_count`, `overflow` and `drop_count` reflect an event one cycle after it.
- Pointer wrap: 2^ADDR_WIDTH−1 rolls to 0 with no gap or repeat.

## Test plan
- Single word, ready high: `s_axis_tvalid` pulse with 0xDEADBEEF.
  - Next cycle: `m_axis_tvalid` = 1, `m_axis_tdata` = 0xDEADBEEF, `fifo_count` = 1.
  - Cycle after: `m_axis_tvalid` = 0, `fifo_count` = 0.
- Fill and overflow, ready held low: write 0..17.
  - `fifo_count` = 16, `overflow` = 1, `drop_count` = 2.
  - Raising ready then reads 0..15 in order, and `m_axis_tvalid` drops after 16 beats.
- Concurrent read and write at count = 5: assert write and ready together for 10 cycles.
  - `fifo_count` stays 5 throughout.
  - The output sequence is the 5 old words followed by the new ones, in order.
- Wrap-around and backpressure:
  - Write 100 incrementing words at one per cycle while ready toggles randomly; no overflow may occur as long as the occupancy bound holds.
  - All 100 words arrive in order, `tdata` is stable while stalled, and `overflow` = 0.
- Clear:
  - After 3 drops, pulse `clear`: `drop_count` = 0 and `overflow` = 0, with FIFO contents unchanged.
  - `clear` coincident with a drop: `drop_count` = 1 and `overflow` = 1.
- Reset mid-stream: with 7 words stored, assert `aresetn` low for one cycle.
  - `fifo_count` = 0, `m_axis_tvalid` = 0, status cleared.
  - The next written word 0x55 is the first one output.
